// File: rtl/mem_master_if.sv
// Command/response and memory-side signals of mem_master, grouped as one bundle.
// master = mem_master side; slave = host/memory side.
interface mem_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic              mem_rw_en;
  logic              mem_rr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_valid_out;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, mem_data_out, mem_valid_out,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_rw_en, mem_rr_en,
           mem_addr, mem_data_in
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, mem_data_out, mem_valid_out,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_rw_en, mem_rr_en,
           mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_master.sv
// Command FIFO + one-at-a-time initiator for the 16x32 register memory.
// Define MEM_MASTER_READBACK_EN to verify every write with a read-back compare.
module mem_master #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_master_if.master  bus,
  output logic          busy
);
  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_RD,
    CAPTURE,
    ISSUE_WR,
    RESP
`ifdef MEM_MASTER_READBACK_EN
    , VERIFY_RD,
    VERIFY_CMP
`endif
  } state_t;

  state_t state, state_nxt;

  logic              fifo_wr    [CMD_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [CMD_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop, fifo_empty;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_in_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  assign fifo_empty    = (count == '0);
  assign bus.cmd_ready = (count != CNT_W'(CMD_DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state == IDLE) && !fifo_empty;

  // Command FIFO: payload storage is not reset, only the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr[wr_ptr]    <= bus.cmd_wr;
      fifo_addr[wr_ptr]  <= bus.cmd_addr;
      fifo_wdata[wr_ptr] <= bus.cmd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (!fifo_empty) state_nxt = fifo_wr[rd_ptr] ? ISSUE_WR : ISSUE_RD;
      ISSUE_RD: state_nxt = CAPTURE;
      CAPTURE:  state_nxt = RESP;
`ifdef MEM_MASTER_READBACK_EN
      ISSUE_WR:   state_nxt = VERIFY_RD;
      VERIFY_RD:  state_nxt = VERIFY_CMP;
      VERIFY_CMP: state_nxt = RESP;
`else
      ISSUE_WR: state_nxt = RESP;
`endif
      RESP:     if (bus.rsp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; enables only exist in the issue states.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_rr_en = 1'b0;
    bus.mem_rw_en = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      ISSUE_RD: begin
        bus.mem_en    = 1'b1;
        bus.mem_rr_en = 1'b1;
      end
      ISSUE_WR: begin
        bus.mem_en    = 1'b1;
        bus.mem_rw_en = 1'b1;
      end
`ifdef MEM_MASTER_READBACK_EN
      VERIFY_RD: begin
        bus.mem_en    = 1'b1;
        bus.mem_rr_en = 1'b1;
      end
`endif
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
    busy = !fifo_empty || (state != IDLE);
  end

  // Address/data are loaded on pop, i.e. on entry to the issue state, so they
  // hold the last issued value at all other times.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      if (pop) begin
        mem_addr_q <= fifo_addr[rd_ptr];
        if (fifo_wr[rd_ptr]) mem_data_in_q <= fifo_wdata[rd_ptr];
      end
      case (state)
        CAPTURE: begin
          rsp_rdata_q <= bus.mem_data_out;
          rsp_err_q   <= !bus.mem_valid_out;
        end
`ifdef MEM_MASTER_READBACK_EN
        VERIFY_CMP: begin
          rsp_rdata_q <= bus.mem_data_out;
          rsp_err_q   <= !bus.mem_valid_out || (bus.mem_data_out != mem_data_in_q);
        end
`else
        ISSUE_WR: begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a behavioural 16x32 register memory attached.
module tb_mem_master;
  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  mem_master_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  mem_master #(.ADDR_W(4), .DATA_W(32), .CMD_DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // Memory model: read data registered on the enable edge, valid is a level.
  logic [31:0] mem_arr [16];
  logic [31:0] mem_q;
  logic        mem_vq;
  logic        force_invalid;
  logic [31:0] corrupt;

  always @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      mem_vq <= 1'b0;
    end else begin
      if (bus.mem_en && bus.mem_rw_en) mem_arr[bus.mem_addr] <= bus.mem_data_in;
      if (bus.mem_en && bus.mem_rr_en) begin
        mem_q  <= mem_arr[bus.mem_addr];
        mem_vq <= 1'b1;
      end
    end
  end

  assign bus.mem_data_out  = mem_q ^ corrupt;
  assign bus.mem_valid_out = mem_vq && !force_invalid;

  int en_pulses = 0;
  int overlap   = 0;
  int b2b       = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_en) en_pulses++;
    if (bus.mem_rr_en && bus.mem_rw_en) overlap++;
    if (prev_en && bus.mem_en) b2b++;
    prev_en = bus.mem_en;
  end

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MEM_MASTER_READBACK_EN
  localparam int WR_LAT = 5;
  function automatic logic [31:0] wr_rdata(input logic [31:0] d);
    return d;
  endfunction
`else
  localparam int WR_LAT = 3;
  function automatic logic [31:0] wr_rdata(input logic [31:0] d);
    return (d & 32'h0);
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [3:0] a, input logic [31:0] d);
    int t;
    t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check("push_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Called right after an accept (cycle 1); exp_lat <= 0 skips the latency check.
  task automatic wait_rsp(input string tag, input logic [31:0] exp_d, input logic exp_e,
                          input int exp_lat);
    int n;
    logic [31:0] seen;
    n = 1;
    while (!bus.rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.rsp_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (exp_lat > 0) check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_rdata"}, bus.rsp_rdata, exp_d);
    check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_e));
    seen = bus.rsp_rdata;
    @(posedge clk); #1;
    check({tag, "_hold"}, {31'd0, bus.rsp_valid} ^ (bus.rsp_rdata ^ seen), 32'd1);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int base;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    force_invalid = 1'b0;
    corrupt       = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);

    // Write then read back the same address, with latency.
    push(1'b1, 4'd3, 32'hDEADBEEF);
    wait_rsp("t1_wr", wr_rdata(32'hDEADBEEF), 1'b0, WR_LAT);
    wait_idle();
    push(1'b0, 4'd3, 32'h0);
    wait_rsp("t1_rd", 32'hDEADBEEF, 1'b0, 4);
    wait_idle();

    // Fill the FIFO while responses are held off.
    base = en_pulses;
    push(1'b1, 4'd5, 32'h11111111);
    push(1'b0, 4'd5, 32'h0);
    push(1'b1, 4'd6, 32'h22222222);
    push(1'b0, 4'd6, 32'h0);
    push(1'b0, 4'd3, 32'h0);
    check("t2_full_ready", 32'(bus.cmd_ready), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("t2_single_issue", 32'(en_pulses - base), 32'd1);
    check("t2_still_full", 32'(bus.cmd_ready), 32'd0);
    wait_rsp("t2_r0", wr_rdata(32'h11111111), 1'b0, 0);
    wait_rsp("t2_r1", 32'h11111111, 1'b0, 0);
    wait_rsp("t2_r2", wr_rdata(32'h22222222), 1'b0, 0);
    wait_rsp("t2_r3", 32'h22222222, 1'b0, 0);
    wait_rsp("t2_r4", 32'hDEADBEEF, 1'b0, 0);
    wait_idle();

    // Sweep every address.
    for (int a = 15; a >= 0; a--) begin
      push(1'b1, 4'(a), 32'(a));
      wait_rsp($sformatf("t3_wr%0d", a), wr_rdata(32'(a)), 1'b0, WR_LAT);
    end
    for (int a = 0; a < 16; a++) begin
      push(1'b0, 4'(a), 32'h0);
      wait_rsp($sformatf("t3_rd%0d", a), 32'(a), 1'b0, 4);
    end
    wait_idle();

    // Memory reports invalid data.
    force_invalid = 1'b1;
    push(1'b0, 4'd7, 32'h0);
    wait_rsp("t4_invalid", 32'd7, 1'b1, 4);
    force_invalid = 1'b0;
    wait_idle();

    // Reset while the read is in CAPTURE (cycle 3).
    push(1'b0, 4'd9, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_mem_en", 32'(bus.mem_en), 32'd0);
    check("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    base = en_pulses;
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_issue", 32'(en_pulses - base), 32'd0);
    check("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
    push(1'b0, 4'd9, 32'h0);
    wait_rsp("t5_recover", 32'd9, 1'b0, 4);
    wait_idle();

`ifdef MEM_MASTER_READBACK_EN
    corrupt = 32'h00000100;
    push(1'b1, 4'd2, 32'hCAFEF00D);
    wait_rsp("t6_verify", 32'hCAFEF00D ^ 32'h00000100, 1'b1, 5);
    corrupt = '0;
    wait_idle();
`endif

    check("no_rr_rw_overlap", 32'(overlap), 32'd0);
    check("no_b2b_enable", 32'(b2b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
